// File: rtl/ladybird_fetch_pkg.sv
// Shared fetch definitions: datapath width and the {pc, inst} entry handed to decode.
package ladybird_config;

  localparam int XLEN       = 32;
  localparam int INST_BYTES = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ladybird_fetch_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module ladybird_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;

  assign do_pop = pop & ~empty;
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign rdata  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!nrst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !do_pop)
        count <= count + CW'(1);
      else if (!push && do_pop)
        count <= count - CW'(1);
    end
  end

  // Storage holds data only; validity is tracked by count, so no reset needed.
  always_ff @(posedge clk) begin
    if (nrst && !flush && push)
      mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ladybird_fetch.sv
// Sequential instruction fetch with one outstanding bridge request and a decode FIFO.
// Optional macro LADYBIRD_FETCH_BYPASS_EN forwards a response straight to out_* when the FIFO is empty.
module ladybird_fetch #(
  parameter int              XLEN     = ladybird_config::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            nrst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic [XLEN-1:0] inst,
  input  logic            inst_valid,
  input  logic            dmem_req,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst
);

  import ladybird_config::*;

  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DISCARD} state_t;

  localparam int CW = $clog2(DEPTH) + 1;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   req_pc;
  logic              issue;
  logic              kept_rsp;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;

  assign pc_valid = nrst & (state == IDLE) & ~fifo_full & ~dmem_req & ~redirect_valid;
  assign pc       = {fetch_pc[XLEN-1:2], 2'b00};
  assign issue    = pc_valid & pc_ready;
  assign kept_rsp = (state == WAIT) & inst_valid & ~redirect_valid;

`ifdef LADYBIRD_FETCH_BYPASS_EN
  assign bypass = kept_rsp & fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word consumed this cycle never needs a FIFO slot.
  assign fifo_push = kept_rsp & ~(bypass & out_ready);
  assign fifo_pop  = ~fifo_empty & out_ready;

  assign out_valid = ~fifo_empty | bypass;
  assign out_pc    = bypass ? req_pc : fifo_rdata[2*XLEN-1:XLEN];
  assign out_inst  = bypass ? inst   : fifo_rdata[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!nrst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // A redirect while waiting turns the pending response stale unless it lands now.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:         if (issue) state_next = WAIT;
      WAIT:         if (inst_valid) state_next = IDLE;
                    else if (redirect_valid) state_next = WAIT_DISCARD;
      WAIT_DISCARD: if (inst_valid) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst)
      fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
    else if (redirect_valid)
      fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
    else if (issue)
      fetch_pc <= fetch_pc + XLEN'(INST_BYTES);
  end

  always_ff @(posedge clk) begin
    if (issue)
      req_pc <= pc;
  end

  ladybird_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (fifo_push),
    .wdata ({req_pc, inst}),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!nrst)
    !(fifo_push && fifo_count == CW'(DEPTH)));

endmodule

// File: tb/tb_ladybird_fetch.sv
// Directed bench for ladybird_fetch: transaction-level model plus bridge responder.
module tb_ladybird_fetch;

  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        nrst;
  logic [31:0] pc;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] inst;
  logic        inst_valid;
  logic        dmem_req;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  ladybird_fetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .nrst(nrst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .inst(inst), .inst_valid(inst_valid), .dmem_req(dmem_req),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: next fetch address, one outstanding request, expected decode queue.
  logic [31:0] m_fetch_pc;
  bit          m_out;
  bit          m_keep;
  logic [63:0] m_q[$];
  int          rsp_timer;
  logic [31:0] rsp_pc;

  bit          g_ready, g_dmem, g_ordy;
  int          g_lat;
  int          cyc;
  bit          last_pv;
  logic [31:0] obs_issue[$];
  int          obs_issue_cyc[$];
  logic [31:0] obs_pop[$];
  logic [31:0] obs_pop_inst[$];
  bit          iv_ov[$];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i >= 0 && i < q.size()) return q[i];
    return 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = '0);
    bit          iv, exp_pv, byp, exp_ov, issue, consumed;
    logic [63:0] head;
    logic [31:0] ipc;
    iv     = (rsp_timer == 1);
    exp_pv = !m_out && (m_q.size() < DEPTH) && !g_dmem && !redir;
    pc_ready       = g_ready;
    dmem_req       = g_dmem;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = g_ordy;
    inst_valid     = iv;
    inst           = iv ? inst_of(rsp_pc) : 32'hBAD0_BAD0;
    #1;
    if (iv) chk("rsp_while_outstanding", 32'(m_out), 32'd1);
    byp = 1'b0;
`ifdef LADYBIRD_FETCH_BYPASS_EN
    byp = m_out && m_keep && iv && !redir && (m_q.size() == 0);
`endif
    exp_ov = (m_q.size() > 0) || byp;
    head   = (m_q.size() > 0) ? m_q[0] : {rsp_pc, inst_of(rsp_pc)};
    chk("pc_valid", 32'(pc_valid), 32'(exp_pv));
    if (exp_pv) chk("pc", pc, m_fetch_pc);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_pc", out_pc, head[63:32]);
      chk("out_inst", out_inst, head[31:0]);
    end
    last_pv = pc_valid;
    if (pc_valid && pc_ready) begin
      obs_issue.push_back(pc);
      obs_issue_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      obs_pop.push_back(out_pc);
      obs_pop_inst.push_back(out_inst);
    end
    if (iv) iv_ov.push_back(out_valid);

    issue = exp_pv && g_ready;
    ipc   = m_fetch_pc;
    if (redir) begin
      m_q.delete();
      m_fetch_pc = {rpc[31:2], 2'b00};
      if (m_out) begin
        if (iv) m_out = 1'b0;
        else    m_keep = 1'b0;
      end
    end else begin
      consumed = 1'b0;
      if (g_ordy && exp_ov) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else consumed = 1'b1;
      end
      if (iv && m_out) begin
        if (m_keep && !consumed) m_q.push_back({rsp_pc, inst_of(rsp_pc)});
        m_out = 1'b0;
      end
      if (issue) begin
        m_out      = 1'b1;
        m_keep     = 1'b1;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    if (rsp_timer > 0) rsp_timer--;
    if (issue) begin
      rsp_timer = g_lat;
      rsp_pc    = ipc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    pc_ready = 1'b0; inst_valid = 1'b0; inst = '0; dmem_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pc_valid", 32'(pc_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    m_q.delete();
    m_out = 1'b0; m_keep = 1'b0; m_fetch_pc = RST_PC; rsp_timer = 0; rsp_pc = '0;
    obs_issue.delete(); obs_issue_cyc.delete(); obs_pop.delete(); obs_pop_inst.delete(); iv_ov.delete();
    g_ready = 1'b1; g_dmem = 1'b0; g_ordy = 1'b1; g_lat = 1;
    nrst = 1'b1;
    #1;
    chk("rst_first_pc", pc, RST_PC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard, n, redir_cyc, cnt;
    cyc = 0;
    chk("inst_of_pin", inst_of(32'h0000_0100), 32'h1257_6420);

    // Straight-line fetch, 1-cycle bridge latency, decode always ready.
    do_reset();
    repeat (12) step();
    chk("t1_issue0", qget(obs_issue, 0), 32'h0000_0100);
    chk("t1_issue1", qget(obs_issue, 1), 32'h0000_0104);
    chk("t1_issue2", qget(obs_issue, 2), 32'h0000_0108);
    chk("t1_pop0", qget(obs_pop, 0), 32'h0000_0100);
    chk("t1_pop1", qget(obs_pop, 1), 32'h0000_0104);
    chk("t1_pop0_inst", qget(obs_pop_inst, 0), 32'h1257_6420);

    // Decode stalled: FIFO fills after exactly DEPTH issues.
    do_reset();
    g_ordy = 1'b0;
    repeat (20) step();
    chk("t2_issue_cnt", 32'(obs_issue.size()), 32'd4);
    chk("t2_pc_valid_full", 32'(pc_valid), 32'd0);
    g_ordy = 1'b1;
    step();
    step();
    chk("t2_issue_resume", 32'(obs_issue.size()), 32'd5);

    // Redirect while 0x108 is outstanding; its response lands two cycles later.
    do_reset();
    g_lat = 3;
    guard = 0;
    while (obs_issue.size() < 3 && guard < 40) begin step(); guard++; end
    chk("t3_wait_issue", 32'(guard < 40), 32'd1);
    chk("t3_last_issue", qget(obs_issue, 2), 32'h0000_0108);
    n = obs_issue.size();
    redir_cyc = cyc;
    step(1'b1, 32'h0000_2002);
    obs_pop.delete();
    repeat (20) step();
    chk("t3_redir_issue", qget(obs_issue, n), 32'h0000_2000);
    chk("t3_redir_delay", 32'(obs_issue_cyc.size() > n ? obs_issue_cyc[n] - redir_cyc : -1), 32'd3);
    chk("t3_first_pop", qget(obs_pop, 0), 32'h0000_2000);

    // Redirect coincident with a response while three entries are queued.
    do_reset();
    g_ordy = 1'b0;
    guard = 0;
    while (!(m_q.size() == 3 && m_out && rsp_timer == 1) && guard < 60) begin step(); guard++; end
    chk("t4_wait_setup", 32'(guard < 60), 32'd1);
    n = obs_issue.size();
    step(1'b1, 32'h0000_3000);
    chk("t4_out_valid_after", 32'(out_valid), 32'd0);
    step();
    step();
    chk("t4_next_issue", qget(obs_issue, n), 32'h0000_3000);

    // dmem_req blocks new issues but the outstanding response still lands.
    do_reset();
    g_ordy = 1'b0;
    g_lat = 3;
    step();
    g_dmem = 1'b1;
    cnt = 0;
    repeat (5) begin step(); cnt += int'(last_pv); end
    chk("t5_pv_during_dmem", 32'(cnt), 32'd0);
    chk("t5_rsp_landed", 32'(out_valid), 32'd1);
    g_dmem = 1'b0;
    step();
    chk("t5_issue_after", qget(obs_issue, 1), 32'h0000_0104);

    // PC wrap at the top of the address space, plus response-cycle visibility.
    do_reset();
    step(1'b1, 32'hFFFF_FFFE);
    repeat (6) step();
    chk("t6_issue_top", qget(obs_issue, 0), 32'hFFFF_FFFC);
    chk("t6_issue_wrap", qget(obs_issue, 1), 32'h0000_0000);
    chk("t6_pop_top", qget(obs_pop, 0), 32'hFFFF_FFFC);
    chk("t6_rsp_seen", 32'(iv_ov.size() > 0), 32'd1);
`ifdef LADYBIRD_FETCH_BYPASS_EN
    chk("t6_same_cycle_out", 32'(iv_ov.size() > 0 ? iv_ov[0] : 1'b0), 32'd1);
`else
    chk("t6_same_cycle_out", 32'(iv_ov.size() > 0 ? iv_ov[0] : 1'b1), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
